cordic_axil_ctrl: RTL and testbench
===================================

Name: cordic_axil_ctrl

Overview:
- AXI4-Lite slave control/status register block for the CORDIC IP.
- Sits between the AXI4-Lite interconnect (driven by the system master) and the sequential CORDIC core.
- Latches the input angle, issues a start command to the core over a valid/ready handshake, waits for the result and captures cos/sin into read-only registers.
- Reports completion through a sticky status bit and a level interrupt.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 5, byte address width covering 8 word registers.
- ANGLE_W, 16, width of the angle and result fields, all signed two's complement; must be ≤ 32.

Ports:
- s00_axi_aclk  in  1  single clock for all logic.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr/awvalid/awready  in/in/out  5/1/1  write address channel; awprot is ignored.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arvalid/arready  in/in/out  5/1/1  read address channel.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- core_cmd_valid  out  1  start request to the core.
- core_cmd_ready  in  1  core accepts the command.
- core_angle  out  ANGLE_W  angle presented with the command.
- core_res_valid  in  1  one-cycle result strobe from the core.
- core_cos, core_sin  in  ANGLE_W each  result values.
- irq  out  1  high while STATUS.DONE=1 and CTRL.IRQ_EN=1.

Behaviour:
- Register map (word aligned; addr[1:0] ignored):
  - 0x00 CTRL: bit0 START, write-1 pulse, reads 0; bit1 IRQ_EN, R/W.
  - 0x04 ANGLE: [ANGLE_W-1:0] R/W; upper bits read 0.
  - 0x08 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 OVERRUN (W1C).
  - 0x0C COS, 0x10 SIN: RO, sign-extended to 32 bits.
  - 0x14–0x1C: unmapped; reads return 0, writes are ignored.
- Responses: bresp and rresp are always OKAY (2'b00).
- Write strobes: wstrb is honoured per byte on R/W fields; W1C bits apply only when byte 0 is enabled.
- Write channel:
  - AW and W are accepted independently (each ready is high while its holding register is empty and bvalid=0).
  - The register update occurs on the cycle after both are held; bvalid asserts that same cycle.
  - bvalid holds until bready; the holding registers free on the B handshake.
  - Minimum write latency is AW/W handshake to bvalid = 1 cycle.
- Read channel:
  - arready = !rvalid.
  - rdata is registered and rvalid rises the cycle after the AR handshake; it holds until rready.
  - A read and a write completing in the same cycle are both serviced; the read returns the pre-write value.
- Control FSM:
  - IDLE: START written → latch ANGLE into core_angle, set BUSY, go to ISSUE.
  - ISSUE: core_cmd_valid=1 until core_cmd_ready, then go to WAIT. core_angle stays stable.
  - WAIT: on core_res_valid, capture COS/SIN, set DONE, clear BUSY, go to IDLE.
- START while BUSY: ignored, and OVERRUN is set.
- Writes to ANGLE during BUSY update the register but not core_angle.
- Hardware set of DONE or OVERRUN in the same cycle as a software W1C: set wins.
- Reset: all registers 0, FSM to IDLE. awready=wready=arready=0 during reset and 1 from the first cycle after release. bvalid=rvalid=0, core_cmd_valid=0, irq=0. Reset mid-transfer discards the transaction.
- core_res_valid outside WAIT is ignored.

Test Plan:
- After reset, read 0x00–0x10 → all 0x00000000, rresp=OKAY; 0x1C read → 0.
- Write ANGLE=0x00002000, then CTRL=0x3; core_cmd_ready is delayed 3 cycles; the core returns cos=0x5A82, sin=0x5A82 → core_angle=0x2000; STATUS reads 0x1 until the result, then 0x2; COS/SIN read 0x00005A82; irq=1.
- Core returns negative sin=0xA57E → SIN reads 0xFFFFA57E.
- Write CTRL=0x1 while BUSY → STATUS=0x5. Write STATUS=0x6 → 0x1. Second result still completes.
- AW presented 4 cycles before W, bready held low 5 cycles → bvalid asserts 1 cycle after W accept and stays high; no second write is accepted until B completes.
- W1C of DONE in the same cycle as core_res_valid → DONE remains 1. Reset asserted during WAIT → BUSY=0, FSM idle, a following START is accepted normally.

Source files
------------

// File: rtl/cordic_axil_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_axil_ctrl_if
//  Description : AXI4-Lite bus bundle between the system master and the
//                CORDIC control/status register block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_axil_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/cordic_axil_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_axil_ctrl
//  Description : AXI4-Lite control/status registers that launch the sequential
//                CORDIC core and capture its cos/sin result.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_axil_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int ANGLE_W            = 16
) (
    input  wire logic               s00_axi_aclk,
    input  wire logic               s00_axi_aresetn,
    cordic_axil_ctrl_if.slave       s00_axi,
    output logic                    core_cmd_valid,
    input  wire logic               core_cmd_ready,
    output logic [ANGLE_W-1:0]      core_angle,
    input  wire logic               core_res_valid,
    input  wire logic [ANGLE_W-1:0] core_cos,
    input  wire logic [ANGLE_W-1:0] core_sin,
    output logic                    irq
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] c_reg_ctrl   = IDX_W'(0);
    localparam logic [IDX_W-1:0] c_reg_angle  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_reg_status = IDX_W'(2);
    localparam logic [IDX_W-1:0] c_reg_cos    = IDX_W'(3);
    localparam logic [IDX_W-1:0] c_reg_sin    = IDX_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                              aw_full_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     aw_addr_q;
    logic                              w_full_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   w_strb_q;
    logic                              bvalid_q;
    logic                              rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q;

    logic                              irq_en_q, irq_en_d;
    logic                              done_q, done_d;
    logic                              overrun_q, overrun_d;
    logic [ANGLE_W-1:0]                angle_q, angle_d;
    logic [ANGLE_W-1:0]                core_angle_q;
    logic [ANGLE_W-1:0]                cos_q, sin_q;

    logic                              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                              w_wr_en, w_start, w_status_wr;
    logic                              w_launch, w_capture, w_busy;
    logic [IDX_W-1:0]                  w_wr_idx, w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_angle_merge;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_rd_data;
    logic                              w_unused;

    // Ready lines are gated by reset so they read low while it is held.
    assign s00_axi.awready = s00_axi_aresetn & ~aw_full_q & ~bvalid_q;
    assign s00_axi.wready  = s00_axi_aresetn & ~w_full_q  & ~bvalid_q;
    assign s00_axi.arready = s00_axi_aresetn & ~rvalid_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;

    assign w_aw_hs = s00_axi.awvalid & s00_axi.awready;
    assign w_w_hs  = s00_axi.wvalid  & s00_axi.wready;
    assign w_b_hs  = bvalid_q & s00_axi.bready;
    assign w_ar_hs = s00_axi.arvalid & s00_axi.arready;
    assign w_r_hs  = rvalid_q & s00_axi.rready;

    assign w_wr_en     = aw_full_q & w_full_q & ~bvalid_q;
    assign w_wr_idx    = aw_addr_q[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx    = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_start     = w_wr_en & (w_wr_idx == c_reg_ctrl) & w_strb_q[0] & w_data_q[0];
    assign w_status_wr = w_wr_en & (w_wr_idx == c_reg_status) & w_strb_q[0];
    assign w_busy      = (state_q != ST_IDLE);

    assign core_cmd_valid = (state_q == ST_ISSUE);
    assign core_angle     = core_angle_q;
    assign irq            = done_q & irq_en_q;

    assign w_unused = ^{aw_addr_q[1:0], s00_axi.araddr[1:0], w_angle_merge};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (w_b_hs) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    aw_full_q <= 1'b1;
                    aw_addr_q <= s00_axi.awaddr;
                end
                if (w_w_hs) begin
                    w_full_q <= 1'b1;
                    w_data_q <= s00_axi.wdata;
                    w_strb_q <= s00_axi.wstrb;
                end
            end
            if (w_wr_en) begin
                bvalid_q <= 1'b1;
            end else if (w_b_hs) begin
                bvalid_q <= 1'b0;
            end
            // Read data is sampled from the registers before any same-edge write lands.
            if (w_ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= w_rd_data;
            end else if (w_r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_rd_idx)
            c_reg_ctrl:   w_rd_data[1]   = irq_en_q;
            c_reg_angle:  w_rd_data      = C_S_AXI_DATA_WIDTH'(angle_q);
            c_reg_status: w_rd_data[2:0] = {overrun_q, done_q, w_busy};
            c_reg_cos:    w_rd_data      = C_S_AXI_DATA_WIDTH'($signed(cos_q));
            c_reg_sin:    w_rd_data      = C_S_AXI_DATA_WIDTH'($signed(sin_q));
            default:      w_rd_data      = '0;
        endcase
    end

    always_comb begin
        w_angle_merge = C_S_AXI_DATA_WIDTH'(angle_q);
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
            if (w_strb_q[b]) begin
                w_angle_merge[8*b +: 8] = w_data_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        angle_d   = angle_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        if (w_wr_en && (w_wr_idx == c_reg_angle)) begin
            angle_d = w_angle_merge[ANGLE_W-1:0];
        end
        if (w_wr_en && (w_wr_idx == c_reg_ctrl) && w_strb_q[0]) begin
            irq_en_d = w_data_q[1];
        end
        if (w_status_wr) begin
            if (w_data_q[1]) done_d    = 1'b0;
            if (w_data_q[2]) overrun_d = 1'b0;
        end
        // Hardware events override a coincident software clear.
        if (w_capture)          done_d    = 1'b1;
        if (w_start && w_busy)  overrun_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        w_launch  = 1'b0;
        w_capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    w_launch = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_cmd_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_res_valid) begin
                    w_capture = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= ST_IDLE;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            angle_q      <= '0;
            core_angle_q <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
        end else begin
            state_q   <= state_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            angle_q   <= angle_d;
            if (w_launch) begin
                core_angle_q <= angle_q;
            end
            if (w_capture) begin
                cos_q <= core_cos;
                sin_q <= core_sin;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_axil_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_axil_ctrl
//  Description : Self-checking bench for cordic_axil_ctrl against a
//                transaction-level register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_axil_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_cmd_valid;
    logic        core_cmd_ready;
    logic [15:0] core_angle;
    logic        core_res_valid;
    logic [15:0] core_cos;
    logic [15:0] core_sin;
    logic        irq;

    always #5 clk = ~clk;

    cordic_axil_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    cordic_axil_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .ANGLE_W            (16)
    ) u_dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus.slave),
        .core_cmd_valid  (core_cmd_valid),
        .core_cmd_ready  (core_cmd_ready),
        .core_angle      (core_angle),
        .core_res_valid  (core_res_valid),
        .core_cos        (core_cos),
        .core_sin        (core_sin),
        .irq             (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference register file
    logic        m_irq_en, m_busy, m_done, m_ovr;
    logic [15:0] m_angle, m_core_angle, m_cos, m_sin;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_irq_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
        m_angle = '0; m_core_angle = '0; m_cos = '0; m_sin = '0;
    endtask

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0:       return {30'd0, m_irq_en, 1'b0};
            1:       return {16'd0, m_angle};
            2:       return {29'd0, m_ovr, m_done, m_busy};
            3:       return 32'(int'($signed(m_cos)));
            4:       return 32'(int'($signed(m_sin)));
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask, merged;
        case (idx)
            0: if (strb[0]) begin
                m_irq_en = data[1];
                if (data[0]) begin
                    if (m_busy) m_ovr = 1'b1;
                    else begin
                        m_busy       = 1'b1;
                        m_core_angle = m_angle;
                    end
                end
            end
            1: begin
                mask   = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
                merged = ({16'd0, m_angle} & ~mask) | (data & mask);
                m_angle = merged[15:0];
            end
            2: if (strb[0]) begin
                if (data[1]) m_done = 1'b0;
                if (data[2]) m_ovr  = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        while (!(aw_done && w_done) && n < 16) begin
            aw_hs = bus.awvalid & bus.awready;
            w_hs  = bus.wvalid & bus.wready;
            @(posedge clk); #1; n++;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1; bus.wvalid  = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!(aw_done && w_done)) check_eq("aw_w_accept_timeout", {30'd0, bus.awready, bus.wready}, 32'd3);
        n = 0;
        while (!bus.bvalid && n < 16) begin @(posedge clk); #1; n++; end
        if (!bus.bvalid) check_eq("bvalid_timeout", 32'(bus.bvalid), 32'd1);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        m_write(int'(addr[4:2]), data, strb);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        bit hs;
        int n;
        hs = 0; n = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        while (!hs && n < 16) begin
            hs = bus.arready;
            @(posedge clk); #1; n++;
        end
        bus.arvalid = 1'b0;
        if (!hs) check_eq("ar_accept_timeout", 32'(bus.arready), 32'd1);
        n = 0;
        while (!bus.rvalid && n < 16) begin @(posedge clk); #1; n++; end
        if (!bus.rvalid) check_eq("rvalid_timeout", 32'(bus.rvalid), 32'd1);
        data = bus.rdata;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int idx);
        logic [31:0] rd;
        axi_read(5'(idx * 4), rd);
        check_eq($sformatf("%s_reg%0d", tag, idx), rd, m_read(idx));
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check_reg(tag, i);
        check_eq({tag, "_irq"}, 32'(irq), 32'(m_done & m_irq_en));
    endtask

    task automatic core_accept(input int delay);
        int n;
        n = 0;
        while (!core_cmd_valid && n < 16) begin @(posedge clk); #1; n++; end
        check_eq("cmd_valid", 32'(core_cmd_valid), 32'd1);
        check_eq("core_angle", 32'(core_angle), 32'(m_core_angle));
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check_eq("cmd_hold", {15'd0, core_cmd_valid, core_angle}, {15'd0, 1'b1, m_core_angle});
        end
        core_cmd_ready = 1'b1;
        @(posedge clk); #1;
        core_cmd_ready = 1'b0;
        check_eq("cmd_drop", 32'(core_cmd_valid), 32'd0);
    endtask

    task automatic core_result(input logic [15:0] c, input logic [15:0] s);
        core_cos = c; core_sin = s; core_res_valid = 1'b1;
        @(posedge clk); #1;
        core_res_valid = 1'b0;
        m_cos = c; m_sin = s; m_done = 1'b1; m_busy = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, d;
        logic [2:0]  idx;
        logic [3:0]  s;

        rst_n = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        core_cmd_ready = 1'b0; core_res_valid = 1'b0; core_cos = '0; core_sin = '0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        check_eq("rst_outs", {28'd0, bus.bvalid, bus.rvalid, core_cmd_valid, irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rst", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
        check_regs("reset");
        axi_read(5'h1C, rd);
        check_eq("unmapped_1c", rd, 32'd0);
        check_eq("rresp", 32'(bus.rresp), 32'd0);

        // First conversion with delayed command accept
        axi_write(5'h04, 32'h0000_2000, 4'hF);
        axi_write(5'h00, 32'h0000_0003, 4'hF);
        check_reg("issue_status", 2);
        core_accept(3);
        check_reg("wait_status", 2);
        core_result(16'h5A82, 16'h5A82);
        check_regs("first_result");
        check_eq("irq_first", 32'(irq), 32'd1);

        // Overrun, W1C and a negative sine
        axi_write(5'h08, 32'h0000_0002, 4'h1);
        axi_write(5'h00, 32'h0000_0003, 4'hF);
        core_accept(1);
        axi_write(5'h00, 32'h0000_0003, 4'hF);
        check_reg("overrun_status", 2);
        axi_write(5'h04, 32'h0000_1234, 4'hF);
        check_eq("core_angle_busy", 32'(core_angle), 32'(m_core_angle));
        axi_write(5'h08, 32'h0000_0006, 4'h1);
        check_reg("w1c_status", 2);
        core_result(16'h5A82, 16'hA57E);
        check_regs("neg_sin");

        // AW four cycles ahead of W, bready held low
        d = $urandom;
        bus.awaddr = 5'h04; bus.awvalid = 1'b1; bus.bready = 1'b0;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        check_eq("aw_held_ready", 32'(bus.awready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("b_before_w", 32'(bus.bvalid), 32'd0);
        bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        check_eq("b_not_early", 32'(bus.bvalid), 32'd0);
        @(posedge clk); #1;
        check_eq("b_latency", 32'(bus.bvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("b_hold_block", {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'd4);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        m_write(1, d, 4'hF);
        check_eq("b_done", {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'd3);
        check_reg("split_write", 1);

        // DONE clear coinciding with the core result
        axi_write(5'h00, 32'h0000_0001, 4'h1);
        core_accept(2);
        bus.awaddr = 5'h08; bus.wdata = 32'h2; bus.wstrb = 4'h1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        core_cos = 16'h1357; core_sin = 16'hFEDC; core_res_valid = 1'b1;
        @(posedge clk); #1;
        core_res_valid = 1'b0;
        check_eq("w1c_race_bvalid", 32'(bus.bvalid), 32'd1);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        m_write(2, 32'h2, 4'h1);
        m_cos = 16'h1357; m_sin = 16'hFEDC; m_done = 1'b1; m_busy = 1'b0;
        check_reg("w1c_race", 2);

        // Result strobe while idle must be ignored
        core_cos = 16'hAAAA; core_sin = 16'h5555; core_res_valid = 1'b1;
        @(posedge clk); #1;
        core_res_valid = 1'b0;
        check_reg("idle_strobe_cos", 3);
        check_reg("idle_strobe_sin", 4);

        // Reset in the middle of a conversion
        axi_write(5'h00, 32'h0000_0001, 4'h1);
        core_accept(0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_cmd", {30'd0, core_cmd_valid, irq}, 32'd0);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;
        check_regs("after_midrst");
        axi_write(5'h04, 32'h0000_0C00, 4'h3);
        axi_write(5'h00, 32'h0000_0001, 4'hF);
        core_accept(1);
        core_result(16'h7FFF, 16'h8001);
        check_regs("post_rst_conv");

        // Randomized register traffic
        for (int it = 0; it < 40; it++) begin
            idx = 3'($urandom_range(0, 7));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if (idx == 3'd0 && $urandom_range(0, 1) == 1) begin
                d[0] = 1'b1; s[0] = 1'b1;
            end
            axi_write({idx, 2'b00}, d, s);
            if (m_busy) begin
                check_reg("rnd_busy", 2);
                if ($urandom_range(0, 1) == 1) begin
                    axi_write({3'($urandom_range(0, 2)), 2'b00}, $urandom, 4'hF);
                end
                core_accept(int'($urandom_range(0, 3)));
                core_result(16'($urandom), 16'($urandom));
            end
            check_reg("rnd", int'($urandom_range(0, 7)));
            check_eq("rnd_irq", 32'(irq), 32'(m_done & m_irq_en));
        end
        check_regs("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
